// File: rtl/float_arb_pkg.sv
// Shared types and constants for the float_adder arbiter.
// State encoding is fixed so that waveforms and debug tools decode it consistently.
package float_arb_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

endpackage

// File: rtl/float_adder_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Returns the first set request at or after the pointer, wrapping at NUM_REQ.
module rr_picker
  import float_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_REQ,
  input  logic [PTR_W-1:0]   i_PTR,
  output logic               o_VALID,
  output logic [PTR_W-1:0]   o_IDX
);

  int w_k;

  // Scan from the farthest offset down so the closest match to i_PTR wins.
  always_comb begin
    o_VALID = 1'b0;
    o_IDX   = {PTR_W{1'b0}};
    w_k     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = (int'(i_PTR) + i) % NUM_REQ;
      if (i_REQ[w_k]) begin
        o_VALID = 1'b1;
        o_IDX   = w_k[PTR_W-1:0];
      end else begin
        o_VALID = o_VALID;
      end
    end
  end

endmodule

// File: rtl/float_adder_arbiter.sv
// Shares a single float_adder between NUM_REQ requesters, one operation at a time,
// granting in round-robin order and routing the result back with STB/ACK handshakes.
module float_adder_arbiter
  import float_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [FLOAT_W*NUM_REQ-1:0] i_REQ_A,
  input  logic [FLOAT_W*NUM_REQ-1:0] i_REQ_B,
  input  logic [NUM_REQ-1:0]       i_REQ_STB,
  output logic [NUM_REQ-1:0]       o_REQ_ACK,
  output logic [FLOAT_W-1:0]       o_RES_Z,
  output logic [NUM_REQ-1:0]       o_RES_STB,
  input  logic [NUM_REQ-1:0]       i_RES_ACK,
  output logic [FLOAT_W-1:0]       o_ADD_A,
  output logic [FLOAT_W-1:0]       o_ADD_B,
  output logic                     o_ADD_STB,
  input  logic                     i_ADD_ACK,
  input  logic [FLOAT_W-1:0]       i_ADD_Z,
  input  logic                     i_ADD_Z_STB,
  output logic                     o_ADD_Z_ACK,
  output logic                     o_BUSY,
  output logic [CNT_W-1:0]         o_OP_CNT
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_grant;

  logic [FLOAT_W-1:0] w_req_a [NUM_REQ];
  logic [FLOAT_W-1:0] w_req_b [NUM_REQ];
  logic               w_pick_valid;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_res_done;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_req_a[k] = i_REQ_A[FLOAT_W*k +: FLOAT_W];
    assign w_req_b[k] = i_REQ_B[FLOAT_W*k +: FLOAT_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_REQ   (i_REQ_STB),
    .i_PTR   (r_rr_ptr),
    .o_VALID (w_pick_valid),
    .o_IDX   (w_pick_idx)
  );

  assign w_win_oh   = NUM_REQ'(1'b1) << w_pick_idx;
  assign w_grant_oh = NUM_REQ'(1'b1) << r_grant;
  // Explicit wrap keeps the pointer legal when NUM_REQ is not a power of two.
  assign w_next_ptr = (r_grant == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : r_grant + PTR_W'(1'b1);
  assign w_res_done = |(o_RES_STB & i_RES_ACK & w_grant_oh);

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= IDLE;
      r_rr_ptr    <= {PTR_W{1'b0}};
      r_grant     <= {PTR_W{1'b0}};
      o_REQ_ACK   <= {NUM_REQ{1'b0}};
      o_RES_Z     <= {FLOAT_W{1'b0}};
      o_RES_STB   <= {NUM_REQ{1'b0}};
      o_ADD_A     <= {FLOAT_W{1'b0}};
      o_ADD_B     <= {FLOAT_W{1'b0}};
      o_ADD_STB   <= 1'b0;
      o_ADD_Z_ACK <= 1'b0;
      o_BUSY      <= 1'b0;
      o_OP_CNT    <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            o_ADD_A   <= w_req_a[w_pick_idx];
            o_ADD_B   <= w_req_b[w_pick_idx];
            r_grant   <= w_pick_idx;
            o_REQ_ACK <= w_win_oh;
            o_BUSY    <= 1'b1;
            r_state   <= ISSUE;
          end else begin
            o_REQ_ACK   <= {NUM_REQ{1'b0}};
            o_RES_STB   <= {NUM_REQ{1'b0}};
            o_ADD_STB   <= 1'b0;
            o_ADD_Z_ACK <= 1'b0;
            o_BUSY      <= 1'b0;
          end
        end
        ISSUE: begin
          // The requester's ack is a single-cycle pulse; operands are already latched.
          o_REQ_ACK <= {NUM_REQ{1'b0}};
          if (o_ADD_STB && i_ADD_ACK) begin
            o_ADD_STB <= 1'b0;
            r_state   <= WAIT;
          end else begin
            o_ADD_STB <= 1'b1;
          end
        end
        WAIT: begin
          if (i_ADD_Z_STB && o_ADD_Z_ACK) begin
            o_RES_Z     <= i_ADD_Z;
            o_ADD_Z_ACK <= 1'b0;
            r_state     <= DELIVER;
          end else begin
            o_ADD_Z_ACK <= 1'b1;
          end
        end
        DELIVER: begin
          if (w_res_done) begin
            o_RES_STB <= {NUM_REQ{1'b0}};
            r_rr_ptr  <= w_next_ptr;
            o_OP_CNT  <= o_OP_CNT + CNT_W'(1'b1);
            o_BUSY    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            o_RES_STB <= w_grant_oh;
          end
        end
        default: begin
          o_REQ_ACK   <= {NUM_REQ{1'b0}};
          o_RES_STB   <= {NUM_REQ{1'b0}};
          o_ADD_STB   <= 1'b0;
          o_ADD_Z_ACK <= 1'b0;
          o_BUSY      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Bench for float_adder_arbiter: a handshake-level float adder stand-in, directed
// scenarios with literal expectations, then randomized traffic against a transaction model.
module tb_float_adder_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
  logic [31:0]     res_z, add_a, add_b, add_z;
  logic            add_stb, add_ack, add_z_stb, add_z_ack, busy;
  logic [CW-1:0]   op_cnt;

  always #5 clk = ~clk;

  float_adder_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_REQ_A(req_a), .i_REQ_B(req_b), .i_REQ_STB(req_stb), .o_REQ_ACK(req_ack),
    .o_RES_Z(res_z), .o_RES_STB(res_stb), .i_RES_ACK(res_ack),
    .o_ADD_A(add_a), .o_ADD_B(add_b), .o_ADD_STB(add_stb), .i_ADD_ACK(add_ack),
    .i_ADD_Z(add_z), .i_ADD_Z_STB(add_z_stb), .o_ADD_Z_ACK(add_z_ack),
    .o_BUSY(busy), .o_OP_CNT(op_cnt)
  );

  // Integer-valued float32 encode/decode (exact for |n| < 2^24).
  function automatic logic [31:0] i2f(input int n);
    logic [31:0] m;
    logic [31:0] f;
    int e;
    if (n == 0) return 32'h0;
    m = (n < 0) ? 32'(-n) : 32'(n);
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    f = m << (23 - e);
    return {(n < 0), 8'(e + 127), f[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int v;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    v = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -v : v;
  endfunction

  // Stand-in float_adder: random result latency, reset by the same i_RST.
  int s_st, s_dly;
  always @(posedge clk) begin
    if (rst) begin
      s_st <= 0; s_dly <= 0; add_ack <= 1'b0; add_z_stb <= 1'b0; add_z <= 32'h0;
    end else begin
      case (s_st)
        0: if (add_stb && add_ack) begin
             add_ack <= 1'b0;
             add_z   <= i2f(f2i(add_a) + f2i(add_b));
             s_dly   <= int'($urandom_range(3));
             s_st    <= 1;
           end else if (add_stb) add_ack <= 1'b1;
        1: if (s_dly == 0) begin add_z_stb <= 1'b1; s_st <= 2; end
           else s_dly <= s_dly - 1;
        2: if (add_z_stb && add_z_ack) begin add_z_stb <= 1'b0; s_st <= 0; end
        default: s_st <= 0;
      endcase
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester-side bench state.
  int       int_a [N], int_b [N], hold_cfg [N], hold_cnt [N];
  logic [N-1:0] waiting, f_req_x, f_res_x;
  bit       noise;

  // Transaction model: who owns the adder and how far its operation has progressed.
  int          m_owner, m_ptr, m_cnt, m_t, m_t_add, m_t_z;
  bit          m_add_done, m_z_done;
  logic [31:0] m_add_a, m_add_b, m_res_z, m_sum, last_res_z;
  int          last_k;
  int          m_order [$];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_t = 0; m_t_add = 0; m_t_z = 0;
    m_add_done = 0; m_z_done = 0; m_add_a = 0; m_add_b = 0; m_res_z = 0; m_sum = 0;
  endtask

  task automatic model_cycle();
    logic [N-1:0] oh, e_req_ack, e_res_stb;
    bit e_add_stb, e_z_ack;
    int g;
    oh        = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_req_ack = (m_owner >= 0 && m_t == 0) ? oh : '0;
    e_add_stb = (m_owner >= 0 && m_t >= 1 && !m_add_done);
    e_z_ack   = (m_add_done && m_t_add >= 1 && !m_z_done);
    e_res_stb = (m_z_done && m_t_z >= 1) ? oh : '0;
    chk("busy", busy, m_owner >= 0);
    chk("req_ack", req_ack, e_req_ack);
    chk("add_stb", add_stb, e_add_stb);
    chk("add_a", add_a, m_add_a);
    chk("add_b", add_b, m_add_b);
    chk("z_ack", add_z_ack, e_z_ack);
    chk("res_stb", res_stb, e_res_stb);
    chk("res_z", res_z, m_res_z);
    chk("op_cnt", op_cnt, m_cnt % (1 << CW));
    f_req_x = rst ? '0 : (req_stb & req_ack);
    f_res_x = rst ? '0 : (res_stb & res_ack);
    if (rst) model_reset();
    else if (m_owner < 0) begin
      if (req_stb != '0) begin
        g = pick(req_stb, m_ptr);
        m_owner = g; m_t = 0; m_add_done = 0; m_z_done = 0;
        m_add_a = i2f(int_a[g]); m_add_b = i2f(int_b[g]);
        m_sum = i2f(int_a[g] + int_b[g]);
        m_order.push_back(g);
      end
    end else begin
      m_t++;
      if (m_add_done) m_t_add++;
      if (m_z_done) m_t_z++;
      if (e_add_stb && add_ack) begin
        m_add_done = 1; m_t_add = 0;
      end else if (e_z_ack && add_z_stb) begin
        m_z_done = 1; m_t_z = 0; m_res_z = m_sum;
      end else if (e_res_stb != '0 && res_ack[m_owner]) begin
        last_res_z = res_z; last_k = m_owner;
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (f_req_x[k]) begin req_stb[k] = 1'b0; waiting[k] = 1'b1; end
      if (f_res_x[k]) begin
        waiting[k] = 1'b0; res_ack[k] = 1'b0; hold_cnt[k] = hold_cfg[k];
      end else if (res_stb[k]) begin
        if (hold_cnt[k] == 0) res_ack[k] = 1'b1;
        else begin hold_cnt[k]--; res_ack[k] = 1'b0; end
      end else res_ack[k] = noise ? 1'($urandom_range(1)) : 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk); model_cycle();
    @(posedge clk); #1; drive();
  endtask

  task automatic issue(input int k, input int a, input int b);
    int_a[k] = a; int_b[k] = b;
    req_a[32*k +: 32] = i2f(a);
    req_b[32*k +: 32] = i2f(b);
    hold_cnt[k] = hold_cfg[k];
    req_stb[k] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || req_stb != '0 || waiting != '0) && c < budget) begin step(); c++; end
    chk("idle_timeout", c < budget, 1'b1);
  endtask

  initial begin
    int c;
    rst = 1'b1; req_stb = '0; res_ack = '0; req_a = '0; req_b = '0;
    waiting = '0; f_req_x = '0; f_res_x = '0; noise = 0; last_res_z = 0; last_k = -1;
    for (int k = 0; k < N; k++) begin int_a[k] = 0; int_b[k] = 0; hold_cfg[k] = 0; hold_cnt[k] = 0; end
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    chk("i2f_one", i2f(1), 32'h3F800000);
    chk("i2f_three", i2f(3), 32'h40400000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_z", res_z, 32'h0);
    chk("rst_ptr", dut.r_rr_ptr, 2'd0);

    // 1: single op on requester 0.
    issue(0, 1, 2);
    wait_idle(200);
    chk("t1_res_z", last_res_z, 32'h40400000);
    chk("t1_k", last_k, 0);
    chk("t1_cnt", op_cnt, 4'd1);
    chk("t1_ptr", dut.r_rr_ptr, 2'd1);

    // 2: all four at once, pointer parked at 0 first.
    issue(3, 2, 2); wait_idle(200);
    m_order.delete();
    for (int k = 0; k < N; k++) issue(k, k + 10, 3);
    wait_idle(400);
    chk("t2_n", m_order.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_order", m_order[k], k);
    chk("t2_ptr", dut.r_rr_ptr, 2'd0);
    chk("t2_cnt", op_cnt, 4'd6);

    // 3: pointer at 1 with requests 0 and 2 pending.
    issue(0, 4, 4); wait_idle(200);
    m_order.delete();
    issue(0, 5, 6); issue(2, 8, -3);
    wait_idle(300);
    chk("t3_first", m_order[0], 2);
    chk("t3_second", m_order[1], 0);
    chk("t3_ptr", dut.r_rr_ptr, 2'd1);

    // 4: result held unacked for 10 cycles, another request pending meanwhile.
    m_order.delete();
    hold_cfg[1] = 10;
    issue(1, 1, -1);
    c = 0;
    while (!res_stb[1] && c < 100) begin step(); c++; end
    chk("t4_res_seen", res_stb[1], 1'b1);
    issue(3, 4, 5);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_z", res_z, 32'h0);
      chk("t4_hold_stb", res_stb, 4'b0010);
      chk("t4_no_ack", req_ack, 4'b0000);
      step();
    end
    hold_cfg[1] = 0;
    wait_idle(300);
    chk("t4_order", m_order.size() == 2 && m_order[1] == 3, 1'b1);
    chk("t4_res3", last_res_z, 32'h41100000);

    // 6: run the counter up to all-ones, then one more op must wrap it.
    c = 0;
    while (op_cnt != 4'hF && c < 20) begin issue(0, c, 1); wait_idle(200); c++; end
    chk("t6_at_max", op_cnt, 4'hF);
    issue(1, 3, 3); wait_idle(200);
    chk("t6_wrap", op_cnt, 4'h0);

    // 5: reset while the adder result is pending.
    issue(2, 7, 5);
    c = 0;
    while (!add_z_ack && c < 100) begin step(); c++; end
    chk("t5_in_wait", add_z_ack, 1'b1);
    rst = 1'b1;
    step();
    chk("t5_busy", busy, 1'b0);
    chk("t5_req_ack", req_ack, 4'b0000);
    chk("t5_res_stb", res_stb, 4'b0000);
    chk("t5_res_z", res_z, 32'h0);
    chk("t5_add_stb", add_stb, 1'b0);
    chk("t5_z_ack", add_z_ack, 1'b0);
    chk("t5_add_a", add_a, 32'h0);
    chk("t5_ptr", dut.r_rr_ptr, 2'd0);
    rst = 1'b0;
    waiting[2] = 1'b0;
    issue(2, 7, 5);
    wait_idle(200);
    chk("t5_res_z_after", last_res_z, 32'h41400000);
    chk("t5_k", last_k, 2);
    chk("t5_cnt", op_cnt, 4'd1);

    // Randomized traffic with ack noise on non-selected result lines.
    noise = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_stb[k] && !waiting[k] && $urandom_range(3) == 0) begin
          hold_cfg[k] = int'($urandom_range(3));
          issue(k, int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000);
        end
      end
      step();
    end
    noise = 0;
    wait_idle(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
